// File: rtl/wb_serial_master_if.sv
// Signal bundle for wb_serial_master: command/response byte streams, Wishbone
// classic master bus and busy flag. 'master' is the bridge side, 'slave' the environment side.
interface wb_serial_master_if;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;

  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  logic        busy_o;

  modport master (
    input  rx_data_i, rx_valid_i, tx_ready_i, wbm_dat_i, wbm_ack_i,
    output rx_ready_o, tx_data_o, tx_valid_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output busy_o
  );

  modport slave (
    output rx_data_i, rx_valid_i, tx_ready_i, wbm_dat_i, wbm_ack_i,
    input  rx_ready_o, tx_data_o, tx_valid_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  busy_o
  );
endinterface

// File: rtl/wb_serial_master.sv
// Byte-stream to Wishbone classic bridge: 0x01 write / 0x02 read commands, LE address/data.
// Optional bus-cycle abort enabled by defining WB_SERIAL_MASTER_TIMEOUT_EN.
module wb_serial_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                wb_clk_i,
  input logic                wb_rst_ni,
  wb_serial_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, RESP} state_t;

  localparam logic [7:0] CMD_WRITE   = 8'h01;
  localparam logic [7:0] CMD_READ    = 8'h02;
  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_BAD_CMD  = 8'hEE;
  localparam logic [7:0] ST_TIMEOUT  = 8'hFF;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        is_write_q, is_write_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] rdat_q, rdat_d;
  logic [7:0]  status_q, status_d;
  logic        has_data_q, has_data_d;
  // Set once the status byte has gone out; cnt_q then walks the 4 read-data bytes.
  logic        data_phase_q, data_phase_d;
  logic        run_q;

`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        timeout_hit;
  assign timeout_hit = (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`endif

  logic rx_fire, tx_fire, in_bus;

  assign in_bus  = (state_q == BUS);
  assign rx_fire = bus.rx_valid_i && bus.rx_ready_o;
  assign tx_fire = bus.tx_valid_o && bus.tx_ready_i;

  assign bus.rx_ready_o = run_q && (state_q inside {IDLE, ADDR, WDATA});
  assign bus.tx_valid_o = (state_q == RESP);
  assign bus.tx_data_o  = (state_q != RESP) ? 8'h00 :
                          data_phase_q      ? rdat_q[{cnt_q, 3'b000} +: 8] : status_q;
  assign bus.wbm_cyc_o  = in_bus;
  assign bus.wbm_stb_o  = in_bus;
  assign bus.wbm_we_o   = in_bus && is_write_q;
  assign bus.wbm_sel_o  = in_bus ? 4'hF : 4'h0;
  assign bus.wbm_adr_o  = adr_q;
  assign bus.wbm_dat_o  = wdat_q;
  assign bus.busy_o     = (state_q != IDLE);

  // NOTE: every *_d is given its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_write_d   = is_write_q;
    adr_d        = adr_q;
    wdat_d       = wdat_q;
    rdat_d       = rdat_q;
    status_d     = status_q;
    has_data_d   = has_data_q;
    data_phase_d = data_phase_q;
`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
`endif

    unique case (state_q)
      IDLE: if (rx_fire) begin
        if (bus.rx_data_i == CMD_WRITE || bus.rx_data_i == CMD_READ) begin
          is_write_d = (bus.rx_data_i == CMD_WRITE);
          state_d    = ADDR;
        end else begin
          status_d   = ST_BAD_CMD;
          has_data_d = 1'b0;
          state_d    = RESP;
        end
      end
      ADDR: if (rx_fire) begin
        adr_d[{cnt_q, 3'b000} +: 8] = bus.rx_data_i;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = is_write_q ? WDATA : BUS;
      end
      WDATA: if (rx_fire) begin
        wdat_d[{cnt_q, 3'b000} +: 8] = bus.rx_data_i;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = BUS;
      end
      BUS: begin
        if (bus.wbm_ack_i) begin
          if (!is_write_q) rdat_d = bus.wbm_dat_i;
          status_d   = ST_OK;
          has_data_d = !is_write_q;
          state_d    = RESP;
        end
`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
        else if (timeout_hit) begin
          status_d   = ST_TIMEOUT;
          has_data_d = 1'b0;
          state_d    = RESP;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
`endif
      end
      RESP: if (tx_fire) begin
        if (!data_phase_q) begin
          if (has_data_q) data_phase_d = 1'b1;
          else            state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Per-state counters restart on every state change.
    if (state_d != state_q) begin
      cnt_d        = 2'd0;
      data_phase_d = 1'b0;
`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
      to_cnt_d     = 16'd0;
`endif
    end
  end

  // NOTE: reset is synchronous and clears every register, so a reset mid-BUS or
  // mid-RESP lands in IDLE with all bus and stream outputs low on the next cycle.
  // NOTE: sequential state uses <= only; always_comb above uses blocking =.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      is_write_q   <= 1'b0;
      adr_q        <= 32'd0;
      wdat_q       <= 32'd0;
      rdat_q       <= 32'd0;
      status_q     <= 8'd0;
      has_data_q   <= 1'b0;
      data_phase_q <= 1'b0;
      run_q        <= 1'b0;
`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
      to_cnt_q     <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_write_q   <= is_write_d;
      adr_q        <= adr_d;
      wdat_q       <= wdat_d;
      rdat_q       <= rdat_d;
      status_q     <= status_d;
      has_data_q   <= has_data_d;
      data_phase_q <= data_phase_d;
      run_q        <= 1'b1;
`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_wb_serial_master.sv
// Directed bench for wb_serial_master: a command-level model predicts bus requests and
// response bytes; a negedge monitor compares them every cycle. Literal checks pin the model.
module tb_wb_serial_master;

  typedef enum int {OC_ACK, OC_TIMEOUT, OC_NONE} outcome_t;
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_serial_master_if bus ();

  wb_serial_master #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_tx[$];
  txn_t       exp_txn[$];
  logic [7:0] tx_log[$];

  int          ack_at   = 0;
  logic [31:0] ack_data = 32'h0;
  int          tx_mode  = 0;   // 0: always ready, 1: toggle, 2: never ready
  int          cyc_age  = 0;
  int          cyc_run  = 0;
  int          last_cyc_len = 0;
  logic [31:0] last_adr = 0, last_dat = 0;
  logic        last_we = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Command-level model: what the bridge must put on the bus and return on tx.
  task automatic model_cmd(input logic [7:0] cmd[$], input outcome_t oc, input logic [31:0] rd);
    txn_t t;
    if (cmd[0] == 8'h01 || cmd[0] == 8'h02) begin
      t.adr = {cmd[4], cmd[3], cmd[2], cmd[1]};
      t.we  = (cmd[0] == 8'h01);
      t.dat = t.we ? {cmd[8], cmd[7], cmd[6], cmd[5]} : 32'h0;
      exp_txn.push_back(t);
      if (oc == OC_TIMEOUT) exp_tx.push_back(8'hFF);
      else if (oc == OC_ACK) begin
        exp_tx.push_back(8'h00);
        if (!t.we) for (int i = 0; i < 4; i++) exp_tx.push_back(rd[8*i +: 8]);
      end
    end else begin
      exp_tx.push_back(8'hEE);
    end
  endtask

  task automatic send_seq(input logic [7:0] cmd[$]);
    logic acc;
    for (int i = 0; i < cmd.size(); i++) begin
      bus.rx_data_i  = cmd[i];
      bus.rx_valid_i = 1'b1;
      acc = 1'b0;
      for (int n = 0; n < 3000 && !acc; n++) begin
        @(negedge clk);
        acc = bus.rx_ready_o;
        sync();
      end
      if (!acc) check("rx_accept_timeout", 32'(i), 32'hFFFF_FFFF);
    end
    bus.rx_valid_i = 1'b0;
  endtask

  // Ends on a negedge with the DUT idle and all expectations consumed.
  task automatic wait_done(input int limit);
    logic done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      done = !bus.busy_o && exp_tx.size() == 0 && exp_txn.size() == 0;
    end
    check("cmd_done", 32'(done), 32'd1);
  endtask

  task automatic wait_for(input string name, input int sel, input int limit);
    logic hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      hit = (sel == 0) ? bus.wbm_cyc_o : bus.tx_valid_o;
    end
    check(name, 32'(hit), 32'd1);
    sync();
  endtask

  // One-clock reset pulse; called at posedge+1, returns at the following negedge.
  task automatic reset_pulse();
    rst_n = 1'b0;
    sync();
    exp_tx.delete();
    exp_txn.delete();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cyc",   32'(bus.wbm_cyc_o),  32'd0);
    check("rst_stb",   32'(bus.wbm_stb_o),  32'd0);
    check("rst_txv",   32'(bus.tx_valid_o), 32'd0);
    check("rst_busy",  32'(bus.busy_o),     32'd0);
  endtask

  // Wishbone slave: ack in the ack_at-th cycle of cyc (0 = never).
  always @(posedge clk) begin
    #1;
    if (bus.wbm_cyc_o) cyc_age++;
    else               cyc_age = 0;
    bus.wbm_ack_i = bus.wbm_cyc_o && ack_at != 0 && cyc_age == ack_at;
    bus.wbm_dat_i = bus.wbm_ack_i ? ack_data : 32'hA5A5_A5A5;
  end

  always @(posedge clk) begin
    #1;
    case (tx_mode)
      0:       bus.tx_ready_i = 1'b1;
      1:       bus.tx_ready_i = ~bus.tx_ready_i;
      default: bus.tx_ready_i = 1'b0;
    endcase
  end

  // Compare process.
  logic       prev_cyc = 0, prev_hold = 0;
  logic [7:0] prev_data = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wbm_cyc_o) begin
        cyc_run++;
        last_adr = bus.wbm_adr_o;
        last_dat = bus.wbm_dat_o;
        last_we  = bus.wbm_we_o;
        if (exp_txn.size() == 0) check("unexpected_cyc", 32'd1, 32'd0);
        else begin
          check("bus_adr", bus.wbm_adr_o, exp_txn[0].adr);
          check("bus_we",  32'(bus.wbm_we_o), 32'(exp_txn[0].we));
          if (exp_txn[0].we) check("bus_dat", bus.wbm_dat_o, exp_txn[0].dat);
        end
        check("bus_sel", 32'(bus.wbm_sel_o), 32'hF);
        check("bus_stb", 32'(bus.wbm_stb_o), 32'd1);
      end else if (prev_cyc) begin
        last_cyc_len = cyc_run;
        cyc_run = 0;
        if (exp_txn.size() != 0) void'(exp_txn.pop_front());
      end
      if (prev_hold && bus.tx_valid_o) check("tx_hold", 32'(bus.tx_data_o), 32'(prev_data));
      if (bus.tx_valid_o && bus.tx_ready_i) begin
        tx_log.push_back(bus.tx_data_o);
        if (exp_tx.size() == 0) check("unexpected_tx", 32'(bus.tx_data_o), 32'hFFFF_FFFF);
        else check("tx_byte", 32'(bus.tx_data_o), 32'(exp_tx.pop_front()));
      end
    end
    prev_cyc  = bus.wbm_cyc_o;
    prev_hold = bus.tx_valid_o && !bus.tx_ready_i;
    prev_data = bus.tx_data_o;
  end

  initial begin
    logic [7:0] wr_cmd[$], rd_cmd[$], bad_cmd[$], wr2_cmd[$];
    int n;
    wr_cmd  = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h30, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    rd_cmd  = '{8'h02, 8'h04, 8'h00, 8'h00, 8'h30};
    bad_cmd = '{8'h7F};
    wr2_cmd = '{8'h01, 8'h44, 8'h33, 8'h22, 8'h11, 8'h78, 8'h56, 8'h34, 8'h12};

    bus.rx_data_i  = 8'h00;
    bus.rx_valid_i = 1'b0;
    bus.tx_ready_i = 1'b1;
    bus.wbm_ack_i  = 1'b0;
    bus.wbm_dat_i  = 32'h0;

    // Reset values.
    @(negedge clk);
    check("rst0_cyc",   32'(bus.wbm_cyc_o),  32'd0);
    check("rst0_we",    32'(bus.wbm_we_o),   32'd0);
    check("rst0_sel",   32'(bus.wbm_sel_o),  32'd0);
    check("rst0_adr",   bus.wbm_adr_o,       32'd0);
    check("rst0_dat",   bus.wbm_dat_o,       32'd0);
    check("rst0_txv",   32'(bus.tx_valid_o), 32'd0);
    check("rst0_txd",   32'(bus.tx_data_o),  32'd0);
    check("rst0_busy",  32'(bus.busy_o),     32'd0);
    check("rst0_rxrdy", 32'(bus.rx_ready_o), 32'd0);
    sync();
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rxrdy_after_reset", 32'(bus.rx_ready_o), 32'd1);
    sync();

    // Write, ack on 3rd bus cycle.
    ack_at = 3;
    model_cmd(wr_cmd, OC_ACK, 32'h0);
    check("model_wr_adr", exp_txn[0].adr, 32'h3000_0010);
    check("model_wr_dat", exp_txn[0].dat, 32'hDEAD_BEEF);
    tx_log.delete();
    send_seq(wr_cmd);
    wait_done(200);
    check("wr_rxrdy_next", 32'(bus.rx_ready_o), 32'd1);
    check("wr_cyc_len", 32'(last_cyc_len), 32'd3);
    check("wr_adr_lit", last_adr, 32'h3000_0010);
    check("wr_dat_lit", last_dat, 32'hDEAD_BEEF);
    check("wr_we_lit",  32'(last_we), 32'd1);
    check("wr_tx_lit",  32'(tx_log.size() == 1 ? tx_log[0] : 8'h5A), 32'h00);
    sync();

    // Read with toggling tx_ready.
    ack_at = 2; ack_data = 32'h1234_5678; tx_mode = 1;
    model_cmd(rd_cmd, OC_ACK, ack_data);
    tx_log.delete();
    send_seq(rd_cmd);
    wait_done(200);
    check("rd_tx_count", 32'(tx_log.size()), 32'd5);
    if (tx_log.size() == 5) begin
      check("rd_tx0", 32'(tx_log[0]), 32'h00);
      check("rd_tx1", 32'(tx_log[1]), 32'h78);
      check("rd_tx2", 32'(tx_log[2]), 32'h56);
      check("rd_tx3", 32'(tx_log[3]), 32'h34);
      check("rd_tx4", 32'(tx_log[4]), 32'h12);
    end
    check("rd_adr_lit", last_adr, 32'h3000_0004);
    check("rd_we_lit",  32'(last_we), 32'd0);
    tx_mode = 0;
    sync();

    // Unknown command.
    model_cmd(bad_cmd, OC_ACK, 32'h0);
    tx_log.delete();
    send_seq(bad_cmd);
    wait_done(50);
    check("bad_rxrdy_next", 32'(bus.rx_ready_o), 32'd1);
    check("bad_tx_lit", 32'(tx_log.size() == 1 ? tx_log[0] : 8'h5A), 32'hEE);
    sync();

    // Back-to-back write then read, no idle gap inserted by the bench.
    ack_at = 1; ack_data = 32'hCAFE_F00D;
    model_cmd(wr2_cmd, OC_ACK, 32'h0);
    model_cmd(rd_cmd, OC_ACK, ack_data);
    send_seq(wr2_cmd);
    send_seq(rd_cmd);
    wait_done(300);
    sync();

    // Bus timeout.
    ack_at = 0;
`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
    model_cmd(rd_cmd, OC_TIMEOUT, 32'h0);
    tx_log.delete();
    send_seq(rd_cmd);
    wait_done(200);
    check("to_cyc_len", 32'(last_cyc_len), 32'd8);
    check("to_tx_lit", 32'(tx_log.size() == 1 ? tx_log[0] : 8'h5A), 32'hFF);
    sync();
`else
    model_cmd(rd_cmd, OC_NONE, 32'h0);
    send_seq(rd_cmd);
    wait_for("noto_cyc_start", 0, 50);
    n = 1;
    for (int i = 1; i < 1000; i++) begin
      @(negedge clk);
      if (bus.wbm_cyc_o) n++;
    end
    check("noto_cyc_1000", 32'(n), 32'd1000);
    sync();
    reset_pulse();
    sync();
`endif

    // Reset during BUS: no response may follow.
    model_cmd(rd_cmd, OC_NONE, 32'h0);
    send_seq(rd_cmd);
    wait_for("rbus_cyc_start", 0, 50);
    sync();
    reset_pulse();
    repeat (5) @(negedge clk);
    check("rbus_no_tx", 32'(bus.tx_valid_o), 32'd0);
    check("rbus_rxrdy", 32'(bus.rx_ready_o), 32'd1);
    sync();

    // Reset during RESP, then a clean write.
    ack_at = 1; tx_mode = 2;
    model_cmd(wr_cmd, OC_ACK, 32'h0);
    send_seq(wr_cmd);
    wait_for("rresp_txv", 1, 50);
    reset_pulse();
    tx_mode = 0;
    sync();
    model_cmd(wr2_cmd, OC_ACK, 32'h0);
    tx_log.delete();
    send_seq(wr2_cmd);
    wait_done(200);
    check("post_rst_adr", last_adr, 32'h1122_3344);
    check("post_rst_dat", last_dat, 32'h1234_5678);
    check("post_rst_tx", 32'(tx_log.size() == 1 ? tx_log[0] : 8'h5A), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
